ps2_kbd_ctrl: RTL and testbench

Keyboard controller that sits directly behind the `ps2_keyboard` receiver FIFO. It pops raw set-2 scancode bytes using the receiver's `ready`/`nextdata_n` handshake and parses E0/F0/E1 prefixes. It tracks which keys are held and delivers one decoded key event per keystroke over a valid/ready interface to the rest of the NPC design.

---
 rtl/ps2_kbd_pkg.sv | 37 +++
 rtl/ps2_key_table.sv | 26 ++
 rtl/ps2_kbd_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard controller.
package ps2_kbd_pkg;

  // Set-2 prefix / control bytes
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_FE = 8'hFE;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;

  // Bytes that follow E1 in the Pause make sequence and are swallowed
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_SETTLE,
    ST_EMIT
  } kbd_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic       pause;  // Pause event: bypasses the held table
  } kbd_evt_t;

  // Acknowledge / error bytes that carry no key information
  function automatic logic is_ack(input logic [7:0] b);
    return (b == SC_FA) || (b == SC_FE) || (b == SC_00) || (b == SC_FF);
  endfunction

endpackage

// File: rtl/ps2_key_table.sv
// 2x256 held-key bitmap indexed [ext][code]; one read port, one write port.
module ps2_key_table (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_ext,
  input  logic [7:0] rd_code,
  output logic       rd_hit,
  input  logic       wr_en,
  input  logic       wr_ext,
  input  logic [7:0] wr_code,
  input  logic       wr_set,
  input  logic       clr_all
);

  logic [1:0][255:0] held;

  assign rd_hit = held[rd_ext][rd_code];

  // Clear-all (keyboard self-test) takes priority over a single write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         held <= '0;
    else if (clr_all) held <= '0;
    else if (wr_en)   held[wr_ext][wr_code] <= wr_set;
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Pops set-2 scancodes from the receiver FIFO, folds prefixes and emits
// one key event per keystroke over valid/ready.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             evt_repeat,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  kbd_state_t state, state_nx;
  logic [7:0] byte_r;
  logic       ext_f, brk_f;
  logic [2:0] skip_cnt;
  kbd_evt_t   evt_q;
  logic       held_hit;

  logic ld_byte, set_ext, set_brk, clr_flags, ld_skip, dec_skip;
  logic ld_evt, ld_pause, clr_tbl, evt_fire;

  // Strobe and valid come straight from state so reset drops them at once
  assign kb_nextdata_n = (state != ST_POP);
  assign evt_valid     = (state == ST_EMIT);
  assign evt_code      = evt_q.code;
  assign evt_ext       = evt_q.ext;
  assign evt_break     = evt_q.brk;
  assign evt_repeat    = evt_q.rep;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next state and byte classification
  always_comb begin
    state_nx  = state;
    ld_byte   = 1'b0;
    set_ext   = 1'b0;
    set_brk   = 1'b0;
    clr_flags = 1'b0;
    ld_skip   = 1'b0;
    dec_skip  = 1'b0;
    ld_evt    = 1'b0;
    ld_pause  = 1'b0;
    clr_tbl   = 1'b0;
    evt_fire  = 1'b0;
    case (state)
      ST_IDLE: if (kb_ready) begin
        ld_byte  = 1'b1;
        state_nx = ST_POP;
      end
      ST_POP: state_nx = ST_SETTLE;
      ST_SETTLE: begin
        state_nx = ST_IDLE;
        if (skip_cnt != 3'd0) begin
          // Inside the Pause sequence: bytes are consumed, not parsed
          dec_skip = 1'b1;
          if (skip_cnt == 3'd1) begin
            ld_pause = 1'b1;
            state_nx = ST_EMIT;
          end
        end else begin
          case (byte_r)
            SC_E0: set_ext = 1'b1;
            SC_F0: set_brk = 1'b1;
            SC_E1: begin
              ld_skip   = 1'b1;
              clr_flags = 1'b1;
            end
            SC_AA: begin
              clr_flags = 1'b1;
              clr_tbl   = 1'b1;
            end
            default: begin
              clr_flags = 1'b1;
              if (!is_ack(byte_r)) begin
                ld_evt   = 1'b1;
                state_nx = ST_EMIT;
              end
            end
          endcase
        end
      end
      ST_EMIT: if (evt_ready) begin
        evt_fire = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Byte capture, prefix flags, Pause skip counter and event payload
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_r   <= '0;
      ext_f    <= 1'b0;
      brk_f    <= 1'b0;
      skip_cnt <= '0;
      evt_q    <= '0;
    end else begin
      if (ld_byte) byte_r <= kb_data;
      if (clr_flags) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else begin
        if (set_ext) ext_f <= 1'b1;
        if (set_brk) brk_f <= 1'b1;
      end
      if (ld_skip)       skip_cnt <= PAUSE_SKIP;
      else if (dec_skip) skip_cnt <= skip_cnt - 3'd1;
      if (ld_evt)
        evt_q <= '{code: byte_r, ext: ext_f, brk: brk_f,
                   rep: !brk_f && held_hit, pause: 1'b0};
      else if (ld_pause)
        evt_q <= '{code: SC_E1, ext: 1'b0, brk: 1'b0, rep: 1'b0, pause: 1'b1};
    end
  end

  // Non-repeat makes (Pause included) count at the handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      press_cnt <= '0;
    else if (evt_fire && !evt_q.brk && !evt_q.rep)
      press_cnt <= press_cnt + CNT_W'(1);
  end

  // Overflow latch; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             ovf_sticky <= 1'b0;
    else if (kb_overflow) ovf_sticky <= 1'b1;
    else if (ovf_clr)     ovf_sticky <= 1'b0;
  end

  ps2_key_table u_tbl (
    .clk     (clk),
    .rst     (rst),
    .rd_ext  (ext_f),
    .rd_code (byte_r),
    .rd_hit  (held_hit),
    .wr_en   (evt_fire && !evt_q.pause),
    .wr_ext  (evt_q.ext),
    .wr_code (evt_q.code),
    .wr_set  (!evt_q.brk),
    .clr_all (clr_tbl)
  );

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: FIFO model + keystroke-level reference model,
// fixed vector table, directed corner sequences and a randomized stream.
module tb_ps2_kbd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       kb_nextdata_n;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext, evt_break, evt_repeat;
  logic [7:0] press_cnt;
  logic       ovf_sticky;
  logic       ovf_clr = 1'b0;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .evt_repeat(evt_repeat),
    .press_cnt(press_cnt), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
  } ev_t;

  int errors = 0;
  int checks = 0;

  logic [7:0] fifo_q[$];
  ev_t        exp_q[$];
  int         cnt_q[$];

  // Reference model: keystroke semantics over the byte stream
  bit m_held[2][256];
  bit m_ext, m_brk;
  int m_skip, m_cnt;

  int  pops = 0, n_got = 0, ready_mode = 0, cnt_exp = 0;
  bit  cnt_pend = 0, stall = 0;
  ev_t last_got, stall_ev, cur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fifo_sync();
    kb_ready = (fifo_q.size() != 0);
    kb_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic m_emit(input logic [7:0] c, input bit e, input bit b, input bit r, input bit pause);
    if (!pause) m_held[e][c] = !b;
    if (!b && !r) m_cnt = (m_cnt + 1) % 256;
    exp_q.push_back({c, e, b, r});
    cnt_q.push_back(m_cnt);
  endtask

  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) m_emit(8'hE1, 0, 0, 0, 1);
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) begin
      m_skip = 7; m_ext = 0; m_brk = 0;
    end else if (b == 8'hAA) begin
      m_ext = 0; m_brk = 0;
      foreach (m_held[i, j]) m_held[i][j] = 0;
    end else if (b == 8'hFA || b == 8'hFE || b == 8'h00 || b == 8'hFF) begin
      m_ext = 0; m_brk = 0;
    end else begin
      m_emit(b, m_ext, m_brk, !m_brk && m_held[m_ext][b], 0);
      m_ext = 0; m_brk = 0;
    end
    fifo_sync();
  endtask

  // One cycle: observe at negedge, service FIFO pop, pick evt_ready, score
  task automatic tick();
    @(negedge clk);
    cur = {evt_code, evt_ext, evt_break, evt_repeat};
    if (cnt_pend) begin
      chk("press_cnt", press_cnt, cnt_exp);
      cnt_pend = 0;
    end
    if (stall) begin
      chk("stall_valid", evt_valid, 1);
      chk("stall_payload", {21'b0, cur}, {21'b0, stall_ev});
    end
    if (evt_valid) chk("no_pop_in_emit", kb_nextdata_n, 1);
    if (!kb_nextdata_n) begin
      pops++;
      chk("pop_nonempty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      fifo_sync();
    end
    case (ready_mode)
      0:       evt_ready = 1'b1;
      1:       evt_ready = 1'($urandom_range(0, 1));
      default: evt_ready = 1'b0;
    endcase
    stall    = evt_valid && !evt_ready;
    stall_ev = cur;
    if (evt_valid && evt_ready) begin
      n_got++;
      last_got = cur;
      chk("evt_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("evt", {21'b0, cur}, {21'b0, exp_q.pop_front()});
        cnt_exp  = cnt_q.pop_front();
        cnt_pend = 1;
      end
    end
  endtask

  task automatic drain(input int bound);
    bit done = 0;
    for (int i = 0; i < bound; i++) begin
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !evt_valid) begin
        done = 1;
        break;
      end
      tick();
    end
    chk("drain_done", done, 1);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fifo_q.delete(); exp_q.delete(); cnt_q.delete();
    foreach (m_held[i, j]) m_held[i][j] = 0;
    m_ext = 0; m_brk = 0; m_skip = 0; m_cnt = 0;
    stall = 0; cnt_pend = 0;
    kb_overflow = 1'b0; ovf_clr = 1'b0; evt_ready = 1'b0;
    fifo_sync();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Fixed vectors: bytes are sent from b[0] upward (LSB byte first)
  typedef struct {
    string       nm;
    int          n;
    logic [63:0] b;
    int          n_evt;
    ev_t         last;
    int          cnt;
  } vec_t;
  vec_t vt[8];

  task automatic set_vec(input int i, input string nm, input int n, input logic [63:0] b,
                         input int ne, input ev_t last, input int cnt);
    vt[i].nm = nm; vt[i].n = n; vt[i].b = b;
    vt[i].n_evt = ne; vt[i].last = last; vt[i].cnt = cnt;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, p0;
    logic [7:0] pal[12];

    set_vec(0, "make",        1, 64'h1C,               1, {8'h1C, 3'b000}, 1);
    set_vec(1, "rep_release", 5, 64'h1C1CF01C1C,       4, {8'h1C, 3'b000}, 2);
    set_vec(2, "ext_break",   3, 64'h75F0E0,           1, {8'h75, 3'b110}, 0);
    set_vec(3, "ext_remake",  7, 64'h0075E075F0E075E0, 3, {8'h75, 3'b100}, 2);
    set_vec(4, "pause",       8, 64'h77F014F0E17714E1, 1, {8'hE1, 3'b000}, 1);
    set_vec(5, "bat",         3, 64'h1CAA1C,           2, {8'h1C, 3'b000}, 2);
    set_vec(6, "prefix_ord",  4, 64'h6BE0E0F0,         1, {8'h6B, 3'b110}, 0);
    set_vec(7, "ack_bytes",   7, 64'h001CFF00FEF0FAE0, 1, {8'h1C, 3'b000}, 1);

    // Reset values
    do_reset();
    #1;
    chk("rst_nextdata_n", kb_nextdata_n, 1);
    chk("rst_valid", evt_valid, 0);
    chk("rst_payload", {evt_code, evt_ext, evt_break, evt_repeat}, 0);
    chk("rst_cnt", press_cnt, 0);
    chk("rst_ovf", ovf_sticky, 0);

    // Latency: capture edge, POP, SETTLE, then valid
    ready_mode = 0;
    tick();
    p0 = pops;
    send(8'h1C);
    tick();
    chk("lat_pop", kb_nextdata_n, 0);
    chk("lat_pop_valid", evt_valid, 0);
    tick();
    chk("lat_settle", kb_nextdata_n, 1);
    chk("lat_settle_valid", evt_valid, 0);
    tick();
    chk("lat_valid", evt_valid, 1);
    chk("lat_code", evt_code, 8'h1C);
    drain(50);
    chk("lat_pops", pops - p0, 1);

    // Table-driven vectors
    for (int v = 0; v < 8; v++) begin
      do_reset();
      ready_mode = 0;
      g0 = n_got; p0 = pops;
      for (int k = 0; k < vt[v].n; k++) begin
        logic [63:0] bb;
        bb = vt[v].b >> (8 * k);
        send(bb[7:0]);
      end
      drain(200);
      chk({vt[v].nm, "_nevt"}, n_got - g0, vt[v].n_evt);
      chk({vt[v].nm, "_last"}, {21'b0, last_got}, {21'b0, vt[v].last});
      chk({vt[v].nm, "_cnt"}, press_cnt, vt[v].cnt);
      chk({vt[v].nm, "_pops"}, pops - p0, vt[v].n);
    end

    // Backpressure: three queued keys, consumer stalls
    do_reset();
    ready_mode = 2;
    g0 = n_got; p0 = pops;
    send(8'h15); send(8'h1D); send(8'h24);
    repeat (13) tick();
    chk("bp_valid", evt_valid, 1);
    chk("bp_code", evt_code, 8'h15);
    chk("bp_fifo", fifo_q.size(), 2);
    chk("bp_pops", pops - p0, 1);
    ready_mode = 0;
    drain(100);
    chk("bp_nevt", n_got - g0, 3);
    chk("bp_last", last_got.code, 8'h24);

    // Counter wrap: 257 distinct presses
    do_reset();
    ready_mode = 0;
    g0 = n_got;
    for (int i = 0; i < 257; i++) begin
      send(8'h1C);
      if (i < 256) begin send(8'hF0); send(8'h1C); end
    end
    drain(40000);
    chk("wrap_cnt", press_cnt, 1);
    chk("wrap_nevt", n_got - g0, 513);

    // Randomized stream with random consumer backpressure
    pal = '{8'h1C, 8'h1D, 8'h23, 8'h75, 8'h6B, 8'hE0, 8'hF0, 8'hF0,
            8'hAA, 8'hFA, 8'hE1, 8'h00};
    do_reset();
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      send(pal[$urandom_range(0, 11)]);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain(20000);
    chk("rand_cnt", press_cnt, m_cnt);

    // Overflow latch: set beats clear, then clear alone
    do_reset();
    ready_mode = 0;
    tick();
    kb_overflow = 1'b1; ovf_clr = 1'b1;
    tick();
    kb_overflow = 1'b0; ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf_sticky, 1);
    tick();
    chk("ovf_hold", ovf_sticky, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf_sticky, 0);

    // Reset while an event is waiting in EMIT
    send(8'h1C);
    drain(50);
    kb_overflow = 1'b1;
    tick();
    kb_overflow = 1'b0;
    ready_mode = 2;
    send(8'h2A);
    for (int i = 0; i < 10 && !evt_valid; i++) tick();
    chk("emit_reached", evt_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("emit_rst_valid", evt_valid, 0);
    chk("emit_rst_nextdata_n", kb_nextdata_n, 1);
    chk("emit_rst_payload", {evt_code, evt_ext, evt_break, evt_repeat}, 0);
    chk("emit_rst_cnt", press_cnt, 0);
    chk("emit_rst_ovf", ovf_sticky, 0);

    // Reset mid-pop drops the strobe at once
    do_reset();
    ready_mode = 0;
    tick();
    send(8'h1C);
    tick();
    chk("midpop_low", kb_nextdata_n, 0);
    #2 rst = 1'b0;
    #1;
    chk("midpop_abort", kb_nextdata_n, 1);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
